// File: rtl/buzz_pkg.sv
// Shared definitions for the buzzer scheduler: state encoding, width helper,
// and the default system clock frequency.
package buzz_pkg;

    localparam int CLK_FREQ_HZ = 100_000_000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        GAP     = 2'd2,
        PREEMPT = 2'd3
    } state_t;

    // Bits needed to index v distinct values (never less than 1).
    function automatic int clog2(input longint v);
        int w;
        w = 0;
        while ((64'(1) << w) < v) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/buzz_scheduler_prio_enc.sv
// Fixed-priority encoder: the lowest set bit of vec wins.
module prio_enc
    import buzz_pkg::*;
#(
    parameter  int N = 2,
    localparam int W = clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         vld
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        idx = '0;
        vld = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = W'(i);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/buzz_scheduler.sv
// Buzzer scheduler: latches melody requests, grants one player at a time by
// fixed priority, runs a watchdog on each grant and enforces a silent gap
// between melodies. Define BUZZ_PREEMPT_EN to let a higher-priority request
// abort the melody that is currently playing.
module buzz_scheduler
    import buzz_pkg::*;
#(
    parameter  int N_SRC           = 2,
    parameter  int GAP_CYCLES      = 10_000_000,
    parameter  int MAX_PLAY_CYCLES = 500_000_000,
    localparam int ID_W            = clog2(N_SRC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] req,
    input  logic [N_SRC-1:0] done,
    input  logic [N_SRC-1:0] melody,
    output logic [N_SRC-1:0] en,
    output logic             buzz,
    output logic             busy,
    output logic [ID_W-1:0]  active_id,
    output logic             timeout
);

    localparam int PLAY_W = clog2(longint'(MAX_PLAY_CYCLES) + 1);
    localparam int GAP_W  = clog2(longint'(GAP_CYCLES) + 1);

    state_t             state, stateNxt;
    logic [N_SRC-1:0]   pending, clrMask;
    logic [N_SRC-1:0]   enNxt;
    logic [ID_W-1:0]    idNxt, gIdx;
    logic               gVld, toutNxt, playEnd;
    logic [PLAY_W-1:0]  playCnt, playNxt;
    logic [GAP_W-1:0]   gapCnt, gapNxt;

    // One encoder serves both the grant choice and the preemption compare.
    prio_enc #(.N(N_SRC)) uGrant (
        .vec (pending),
        .idx (gIdx),
        .vld (gVld)
    );

    assign busy    = (state != IDLE);
    assign playEnd = done[active_id] || (playCnt == PLAY_W'(MAX_PLAY_CYCLES - 1));

    // Next-state and next-output decode; a grant also clears its pending bit.
    always_comb begin
        stateNxt = state;
        enNxt    = en;
        idNxt    = active_id;
        toutNxt  = 1'b0;
        playNxt  = playCnt;
        gapNxt   = gapCnt;
        clrMask  = '0;
        case (state)
            IDLE
`ifdef BUZZ_PREEMPT_EN
            , PREEMPT
`endif
            : begin
                if (gVld) begin
                    enNxt        = '0;
                    enNxt[gIdx]  = 1'b1;
                    clrMask[gIdx] = 1'b1;
                    idNxt        = gIdx;
                    playNxt      = '0;
                    stateNxt     = PLAY;
                end
            end
            PLAY: begin
                playNxt = playCnt + PLAY_W'(1);
                if (playEnd) begin
                    // A real done wins over a coincident watchdog expiry.
                    enNxt   = '0;
                    idNxt   = '0;
                    toutNxt = !done[active_id];
                    if (GAP_CYCLES == 0) begin
                        stateNxt = IDLE;
                    end else begin
                        stateNxt = GAP;
                        gapNxt   = GAP_W'(GAP_CYCLES - 1);
                    end
                end
`ifdef BUZZ_PREEMPT_EN
                else if (gVld && (gIdx < active_id)) begin
                    enNxt    = '0;
                    idNxt    = '0;
                    stateNxt = PREEMPT;
                end
`endif
            end
            GAP: begin
                if (gapCnt == '0) stateNxt = IDLE;
                else              gapNxt   = gapCnt - GAP_W'(1);
            end
            default: stateNxt = IDLE;
        endcase
    end

    // State, outputs and counters; reset silences the buzzer immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            en        <= '0;
            buzz      <= 1'b0;
            active_id <= '0;
            timeout   <= 1'b0;
            playCnt   <= '0;
            gapCnt    <= '0;
        end else begin
            state     <= stateNxt;
            pending   <= (pending & ~clrMask) | req;
            en        <= enNxt;
            buzz      <= (state == PLAY) ? melody[active_id] : 1'b0;
            active_id <= idNxt;
            timeout   <= toutNxt;
            playCnt   <= playNxt;
            gapCnt    <= gapNxt;
        end
    end

endmodule

// File: tb/tb_buzz_scheduler.sv
// Randomized scoreboard bench for buzz_scheduler (2 sources, short gap and
// watchdog). The stimulus process advances a behavioural model and queues the
// expected outputs; a monitor compares them after every clock edge.
module tb_buzz_scheduler;

    localparam int NS   = 2;
    localparam int GAPC = 4;
    localparam int MAXP = 50;

    localparam int M_IDLE = 0, M_PLAY = 1, M_GAP = 2, M_PRE = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NS-1:0] req, done, melody, en;
    logic          buzz, busy, timeout;
    logic [0:0]    active_id;

    typedef struct {
        logic [1:0] en;
        logic       buzz;
        logic       busy;
        int         id;
        logic       tout;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // model state
    bit [1:0] mPend;
    int       mMode, mCur, mAge, mGap;
    logic     mBuzz, mTout;

    buzz_scheduler #(
        .N_SRC(NS), .GAP_CYCLES(GAPC), .MAX_PLAY_CYCLES(MAXP)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .done(done), .melody(melody),
        .en(en), .buzz(buzz), .busy(busy), .active_id(active_id), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input bit [1:0] p);
        for (int i = 0; i < NS; i++) if (p[i]) return i;
        return -1;
    endfunction

    // Drive one cycle of inputs at the falling edge and queue what the DUT
    // must show after the following rising edge.
    task automatic step(input logic r, input logic [1:0] rq, input logic [1:0] dn, input logic [1:0] ml);
        exp_t     e;
        bit [1:0] clr;
        bit       wasPlay;
        int       oldCur;
        @(negedge clk);
        rst = r; req = rq; done = dn; melody = ml;
        wasPlay = (mMode == M_PLAY);
        oldCur  = mCur;
        clr     = '0;
        mTout   = 1'b0;
        if (r) begin
            mMode = M_IDLE; mPend = '0; mCur = 0; mAge = 0; mGap = 0; mBuzz = 1'b0;
        end else begin
            case (mMode)
                M_IDLE, M_PRE: if (mPend != 0) begin
                    mCur = lowest(mPend); clr[mCur] = 1'b1; mAge = 0; mMode = M_PLAY;
                end
                M_PLAY: begin
                    mAge++;
                    if (dn[mCur] || mAge == MAXP) begin
                        mTout = !dn[mCur];
                        mMode = (GAPC == 0) ? M_IDLE : M_GAP;
                        mGap  = GAPC;
                    end
`ifdef BUZZ_PREEMPT_EN
                    else if (mPend != 0 && lowest(mPend) < mCur) mMode = M_PRE;
`endif
                end
                M_GAP: if (mGap == 1) mMode = M_IDLE; else mGap--;
                default: mMode = M_IDLE;
            endcase
            mPend = (mPend & ~clr) | rq;
            mBuzz = wasPlay ? ml[oldCur] : 1'b0;
        end
        e.en = '0;
        if (mMode == M_PLAY) e.en[mCur] = 1'b1;
        e.buzz = mBuzz;
        e.busy = (mMode != M_IDLE);
        e.id   = (mMode == M_PLAY) ? mCur : 0;
        e.tout = mTout;
        q.push_back(e);
    endtask

    function automatic logic [1:0] rndReq();
        return {($urandom_range(15) == 0), ($urandom_range(15) == 0)};
    endfunction

    function automatic logic [1:0] rndDone();
        return {($urandom_range(19) == 0), ($urandom_range(19) == 0)};
    endfunction

    // Monitor: compare queued expectations just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("en", en, e.en);
                chk("buzz", buzz, e.buzz);
                chk("busy", busy, e.busy);
                chk("active_id", active_id, e.id);
                chk("timeout", timeout, e.tout);
                chk("en_onehot", ($countones(en) <= 1), 1);
            end
        end
    end

    // Stimulus
    initial begin
        int guard;
        mPend = '0; mMode = M_IDLE; mCur = 0; mAge = 0; mGap = 0; mBuzz = 1'b0; mTout = 1'b0;
        rst = 1'b1; req = '0; done = '0; melody = '0;
        #1;
        chk("rst_en", en, 0);
        chk("rst_buzz", buzz, 0);
        chk("rst_busy", busy, 0);
        chk("rst_id", active_id, 0);
        chk("rst_timeout", timeout, 0);
        repeat (3) step(1'b1, '0, '0, '0);

        // simultaneous requests from idle: source 0 first, then source 1
        step(1'b0, 2'b11, '0, 2'($urandom));
        repeat (10) step(1'b0, '0, '0, 2'($urandom));
        step(1'b0, '0, 2'b01, 2'($urandom));
        repeat (20) step(1'b0, '0, '0, 2'($urandom));
        step(1'b0, 2'b10, 2'b10, 2'($urandom));   // done + replay request together
        repeat (20) step(1'b0, '0, 2'b10 & rndDone(), 2'($urandom));

        // general random traffic
        repeat (3000) step(1'b0, rndReq(), rndDone(), 2'($urandom));

        // no done pulses: every grant ends by watchdog
        repeat (800) step(1'b0, rndReq(), '0, 2'($urandom));

        // get source 0 playing, queue source 1, then reset mid-melody
        guard = 0;
        while (!(mMode == M_PLAY && mCur == 0 && mAge > 3) && guard < 500) begin
            step(1'b0, 2'b01, '0, 2'b11);
            guard++;
        end
        chk("reach_play0", guard < 500, 1);
        step(1'b0, 2'b10, '0, 2'b11);
        step(1'b1, '0, '0, 2'b11);
        #1;
        chk("async_en", en, 0);
        chk("async_buzz", buzz, 0);
        chk("async_busy", busy, 0);
        repeat (2) step(1'b1, 2'b11, '0, 2'b11);
        repeat (20) step(1'b0, '0, '0, 2'($urandom));

        // source 1 playing while source 0 requests (preemption path if built)
        step(1'b0, 2'b10, '0, 2'($urandom));
        repeat (5) step(1'b0, '0, '0, 2'($urandom));
        step(1'b0, 2'b01, '0, 2'($urandom));
        repeat (80) step(1'b0, '0, rndDone(), 2'($urandom));

        repeat (1500) step(1'b0, rndReq(), rndDone(), 2'($urandom));

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/buzz_scheduler.md
Name: buzz_scheduler

Overview:
Schedules N_SRC melody players onto the single piezo buzzer output. Each request is latched as pending. The highest-priority pending source is granted: its en is asserted until its done pulse (or a watchdog timeout), then a silent inter-melody gap is enforced before the next grant. Sits between the button edge detectors and the melody player instances, and drives the top-level buzz pin.

Parameters:
N_SRC, 2, number of melody sources; index 0 has the highest priority.
GAP_CYCLES, 10_000_000, silent clk cycles between melodies (100 ms at 100 MHz); 0 means no gap.
MAX_PLAY_CYCLES, 500_000_000, watchdog limit on one grant (5 s); the counter must hold this value.

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  asynchronous, active-high reset
req  input  N_SRC  one-cycle request pulses (already debounced and edge-detected)
done  input  N_SRC  one-cycle end-of-melody pulses from the players
melody  input  N_SRC  PWM outputs from the players
en  output  N_SRC  one-hot (or zero) run enable to the players
buzz  output  1  registered buzzer drive
busy  output  1  high in PLAY, GAP or PREEMPT
active_id  output  clog2(N_SRC) (min 1)  index of the current grant; 0 when idle
timeout  output  1  one-cycle pulse when the watchdog aborts a grant

Behaviour:
- Reset, async: state=IDLE; pending, en, buzz, busy, active_id, timeout, gap counter and play counter all 0. Reset mid-melody silences buzz immediately and discards all pending requests.
- pending[i] is set by req[i]=1, cleared on the edge that grants i; set dominates clear.
- req[i] during i's own playback or during GAP sets pending[i], so the melody replays after the gap. Repeated req while already pending has no effect (no counting).
- Priority: fixed; lowest set index of pending wins.
- FSM:
  - IDLE: if pending≠0 → en[g]<=1, active_id<=g, play counter<=0, → PLAY.
  - PLAY: play counter increments. On done[g]: en<=0 → GAP, or → IDLE if GAP_CYCLES=0. On play counter=MAX_PLAY_CYCLES-1: same exit, plus timeout<=1 for 1 cycle. done on non-granted indices is ignored.
  - GAP: counter loads GAP_CYCLES-1 on entry and counts down; at 0 → IDLE. buzz=0 throughout.
- Latency: req sampled at edge k → pending after k → en after k+1. buzz follows melody[g] with 1 cycle of register delay.
- buzz <= (state==PLAY) ? melody[active_id] : 0. No glitches at state boundaries.
- en is never multi-hot. en drops for at least 1 cycle between any two grants, including re-granting the same source, so players restart from note 0.
- done[g] and req[g] on the same cycle: the grant ends and pending[g] is set (replay).

Optional Feature:
Macro BUZZ_PREEMPT_EN.
- Defined: in PLAY, if pending has an index lower than g → en<=0, → PREEMPT for 1 cycle (buzz=0), then grant the new winner without a gap. The preempted melody is discarded; pending[g] is not restored.
- Undefined: no preemption; the current melody always runs to done or timeout. The PREEMPT state is not built.

Decomposition:
- Package buzz_pkg: state encoding constants (IDLE, PLAY, GAP, PREEMPT), clog2 function, default clock frequency constant.
- Sub-module prio_enc: parameterized fixed-priority encoder, N_SRC in → index plus valid. Reused for the grant and preempt compares.

Test Plan (N_SRC=2, GAP_CYCLES=4, MAX_PLAY_CYCLES=50):
- req=01 at cycle 10 → en=01 at cycle 12. done[0] at 30 → en=00 at 31, busy stays high until the gap ends (4 cycles), then IDLE.
- req=11 on the same cycle → source 0 plays first, then the gap, then en=10. Check en is never 11.
- No done after grant → en drops after 50 cycles of PLAY and timeout pulses exactly 1 cycle.
- req[1] during source 1 playback → after done and the gap, en[1] drops for ≥1 cycle and re-asserts.
- rst asserted mid-PLAY while pending=10 → en, buzz and pending are 0 asynchronously; after release, no grant without a new req.
- BUZZ_PREEMPT_EN defined: source 1 playing, req[0] → en[1]=0 next cycle, one PREEMPT cycle, then en[0]=1. Source 1 does not replay. Undefined: source 0 waits until done[1] plus the gap.
